// File: rtl/hazard_stall_unit_pkg.sv
// Shared LC-3b types for the hazard/stall controller.
//   lc3b_opcode      : 4-bit instruction opcode (op_*)
//   lc3b_reg         : 3-bit register index R0..R7
//   lc3b_stall_state : stall controller FSM state
//   is_load()        : true for opcodes that read data memory into a register
package hazard_stall_unit_pkg;

   typedef enum logic [3:0] {
      op_br   = 4'b0000,
      op_add  = 4'b0001,
      op_ldb  = 4'b0010,
      op_stb  = 4'b0011,
      op_jsr  = 4'b0100,
      op_and  = 4'b0101,
      op_ldr  = 4'b0110,
      op_str  = 4'b0111,
      op_rti  = 4'b1000,
      op_not  = 4'b1001,
      op_ldi  = 4'b1010,
      op_sti  = 4'b1011,
      op_jmp  = 4'b1100,
      op_shf  = 4'b1101,
      op_lea  = 4'b1110,
      op_trap = 4'b1111
   } lc3b_opcode;

   typedef logic [2:0] lc3b_reg;

   typedef enum logic {
      S_IDLE   = 1'b0,
      S_BUBBLE = 1'b1
   } lc3b_stall_state;

   // STI/STB/STR also touch memory but write no register, so they are excluded.
   function automatic logic is_load(lc3b_opcode op);
      return (op == op_ldb) || (op == op_ldr) || (op == op_ldi);
   endfunction

endpackage

// File: rtl/hazard_stall_unit_compare.sv
// Combinational read-after-write comparator between the ID-stage sources
// and the destination of a load sitting in EX.
//   id_sr1/id_sr1_used, id_sr2/id_sr2_used : ID source registers and read enables
//   ex_opcode/ex_dest/ex_regwrite          : EX instruction
//   hazard                                 : true RAW dependency on a load result
//   ex_is_ldi                              : EX op is LDI (needs extra bubbles)
module hazard_compare
   import hazard_stall_unit_pkg::*;
(
   input  logic [2:0] id_sr1,
   input  logic       id_sr1_used,
   input  logic [2:0] id_sr2,
   input  logic       id_sr2_used,
   input  logic [3:0] ex_opcode,
   input  logic [2:0] ex_dest,
   input  logic       ex_regwrite,
   output logic       hazard,
   output logic       ex_is_ldi
);

   lc3b_opcode op;
   logic       sr1_match;
   logic       sr2_match;

   assign op        = lc3b_opcode'(ex_opcode);
   assign sr1_match = id_sr1_used && (id_sr1 == ex_dest);
   assign sr2_match = id_sr2_used && (id_sr2 == ex_dest);
   assign hazard    = is_load(op) && ex_regwrite && (sr1_match || sr2_match);
   assign ex_is_ldi = (op == op_ldi);

endmodule

// File: rtl/hazard_stall_unit.sv
// Load-use and memory-wait stall controller for the 5-stage LC-3b pipeline.
// Stalls IF/ID for nb bubbles on a load-use RAW hazard (extra for LDI),
// follows every bubble run with one unstalled guard cycle, freezes the whole
// pipe on I/D memory waits, cancels pending bubbles on flush, and counts
// stalled cycles in a saturating counter.
// Ports:
//   clk, rst                 : clock, async active-high reset
//   id_sr1/_used, id_sr2/_used: ID-stage source registers and read enables
//   ex_opcode, ex_dest, ex_regwrite : EX-stage instruction
//   imem_busy, dmem_busy     : memory wait requests
//   flush                    : taken branch/jump squashes younger stages
//   stall_front              : hold PC and IF/ID
//   bubble_ex                : load NOP into ID/EX
//   freeze_all               : hold every pipeline register
//   stall_count              : saturating count of stalled/frozen cycles
module hazard_stall_unit
   import hazard_stall_unit_pkg::*;
#(
   parameter int LOAD_BUBBLES = 1,
   parameter int LDI_EXTRA    = 1,
   parameter int CNT_W        = 3,
   parameter int PERF_W       = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [2:0]        id_sr1,
   input  logic              id_sr1_used,
   input  logic [2:0]        id_sr2,
   input  logic              id_sr2_used,
   input  logic [3:0]        ex_opcode,
   input  logic [2:0]        ex_dest,
   input  logic              ex_regwrite,
   input  logic              imem_busy,
   input  logic              dmem_busy,
   input  logic              flush,
   output logic              stall_front,
   output logic              bubble_ex,
   output logic              freeze_all,
   output logic [PERF_W-1:0] stall_count
);

   lc3b_stall_state   state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [PERF_W-1:0] stall_count_q, stall_count_d;
   logic              hazard;
   logic              ex_is_ldi;
   logic [CNT_W-1:0]  nb;

   hazard_compare u_cmp (
      .id_sr1      (id_sr1),
      .id_sr1_used (id_sr1_used),
      .id_sr2      (id_sr2),
      .id_sr2_used (id_sr2_used),
      .ex_opcode   (ex_opcode),
      .ex_dest     (ex_dest),
      .ex_regwrite (ex_regwrite),
      .hazard      (hazard),
      .ex_is_ldi   (ex_is_ldi)
   );

   assign nb = CNT_W'(LOAD_BUBBLES) + (ex_is_ldi ? CNT_W'(LDI_EXTRA) : '0);

   // Next state and outputs. Priority: memory wait > flush > hazard.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      stall_front = 1'b0;
      bubble_ex   = 1'b0;
      freeze_all  = 1'b0;
      if (rst) begin
         // Outputs stay quiet for the whole reset window.
         state_d = S_IDLE;
         cnt_d   = '0;
      end else if (imem_busy || dmem_busy) begin
         // Whole pipe holds, so the bubble schedule holds with it.
         freeze_all = 1'b1;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (!flush && hazard) begin
                  // First bubble is issued in the detecting cycle itself.
                  stall_front = 1'b1;
                  bubble_ex   = 1'b1;
                  cnt_d       = nb - CNT_W'(1);
                  state_d     = S_BUBBLE;
               end
            end
            S_BUBBLE: begin
               if (flush) begin
                  cnt_d   = '0;
                  state_d = S_IDLE;
               end else if (cnt_q != '0) begin
                  stall_front = 1'b1;
                  bubble_ex   = 1'b1;
                  cnt_d       = cnt_q - CNT_W'(1);
               end else begin
                  // Guard cycle: EX still shows the stale load, so the
                  // hazard check is skipped to avoid re-triggering.
                  state_d = S_IDLE;
               end
            end
            default: begin
               state_d = S_IDLE;
               cnt_d   = '0;
            end
         endcase
      end
   end

   always_comb begin
      stall_count_d = stall_count_q;
      if ((stall_front || freeze_all) && !(&stall_count_q))
         stall_count_d = stall_count_q + PERF_W'(1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= S_IDLE;
         cnt_q         <= '0;
         stall_count_q <= '0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         stall_count_q <= stall_count_d;
      end
   end

   assign stall_count = stall_count_q;

endmodule

// File: tb/tb_hazard_stall_unit.sv
module tb_hazard_stall_unit;
   import hazard_stall_unit_pkg::*;

   logic       clk = 1'b0;
   logic       rst;
   logic [2:0] id_sr1, id_sr2, ex_dest;
   logic       id_sr1_used, id_sr2_used, ex_regwrite;
   logic [3:0] ex_opcode;
   logic       imem_busy, dmem_busy, flush;
   logic       stall_front, bubble_ex, freeze_all;
   logic [3:0] stall_count;

   int         n_vec = 0;
   int         n_err = 0;
   logic [3:0] exp_cnt = 4'd0;

   always #5 clk = ~clk;

   hazard_stall_unit #(
      .LOAD_BUBBLES (1),
      .LDI_EXTRA    (1),
      .CNT_W        (3),
      .PERF_W       (4)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .id_sr1      (id_sr1),
      .id_sr1_used (id_sr1_used),
      .id_sr2      (id_sr2),
      .id_sr2_used (id_sr2_used),
      .ex_opcode   (ex_opcode),
      .ex_dest     (ex_dest),
      .ex_regwrite (ex_regwrite),
      .imem_busy   (imem_busy),
      .dmem_busy   (dmem_busy),
      .flush       (flush),
      .stall_front (stall_front),
      .bubble_ex   (bubble_ex),
      .freeze_all  (freeze_all),
      .stall_count (stall_count)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic drv(input logic [2:0] s1, input logic u1, input logic [2:0] s2,
                      input logic u2, input logic [3:0] op, input logic [2:0] d,
                      input logic rw);
      id_sr1 = s1; id_sr1_used = u1; id_sr2 = s2; id_sr2_used = u2;
      ex_opcode = op; ex_dest = d; ex_regwrite = rw;
   endtask

   task automatic idle();
      drv(3'd0, 1'b0, 3'd0, 1'b0, op_add, 3'd0, 1'b0);
   endtask

   // One pipeline cycle: check outputs mid-cycle, advance the count model,
   // then step past the rising edge.
   task automatic cyc(input string tag, input logic esf, input logic ebx, input logic efz);
      @(negedge clk);
      chk({tag, ".stall_front"}, 32'(stall_front), 32'(esf));
      chk({tag, ".bubble_ex"},   32'(bubble_ex),   32'(ebx));
      chk({tag, ".freeze_all"},  32'(freeze_all),  32'(efz));
      chk({tag, ".stall_count"}, 32'(stall_count), 32'(exp_cnt));
      if (esf || efz) exp_cnt = (exp_cnt == 4'd15) ? 4'd15 : exp_cnt + 4'd1;
      @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      rst = 1'b1; imem_busy = 1'b0; dmem_busy = 1'b0; flush = 1'b0;
      drv(3'd1, 1'b1, 3'd3, 1'b1, op_ldr, 3'd1, 1'b1);  // hazard present during reset
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst.stall_front", 32'(stall_front), 32'd0);
      chk("rst.bubble_ex",   32'(bubble_ex),   32'd0);
      chk("rst.freeze_all",  32'(freeze_all),  32'd0);
      chk("rst.stall_count", 32'(stall_count), 32'd0);
      rst = 1'b0;
      idle();
      @(posedge clk); #1;

      // 1: LDR R1 / ADD R2,R1,R3 -> one bubble, then guard
      drv(3'd1, 1'b1, 3'd3, 1'b1, op_ldr, 3'd1, 1'b1);
      cyc("t1.stall", 1, 1, 0);
      cyc("t1.guard", 0, 0, 0);
      idle();
      cyc("t1.idle", 0, 0, 0);

      // 2: LDI R4, sr2=R4 -> two bubbles, guard
      drv(3'd0, 1'b1, 3'd4, 1'b1, op_ldi, 3'd4, 1'b1);
      cyc("t2.stall0", 1, 1, 0);
      cyc("t2.stall1", 1, 1, 0);
      cyc("t2.guard",  0, 0, 0);
      idle();
      cyc("t2.idle", 0, 0, 0);

      // 3: no-hazard patterns
      drv(3'd5, 1'b0, 3'd5, 1'b0, op_ldr, 3'd5, 1'b1); cyc("t3.unused",  0, 0, 0);
      drv(3'd5, 1'b1, 3'd5, 1'b1, op_add, 3'd5, 1'b1); cyc("t3.add",     0, 0, 0);
      drv(3'd5, 1'b1, 3'd5, 1'b1, op_str, 3'd5, 1'b1); cyc("t3.str",     0, 0, 0);
      drv(3'd5, 1'b1, 3'd5, 1'b1, op_sti, 3'd5, 1'b1); cyc("t3.sti",     0, 0, 0);
      drv(3'd5, 1'b1, 3'd5, 1'b1, op_ldr, 3'd5, 1'b0); cyc("t3.nowrite", 0, 0, 0);
      drv(3'd6, 1'b1, 3'd4, 1'b1, op_ldb, 3'd5, 1'b1); cyc("t3.nomatch", 0, 0, 0);
      drv(3'd6, 1'b1, 3'd5, 1'b1, op_ldb, 3'd5, 1'b1); cyc("t3.ldb",     1, 1, 0);
      cyc("t3.ldb_guard", 0, 0, 0);
      idle();

      // 4: imem wait before hazard, then dmem wait mid-bubble
      drv(3'd2, 1'b1, 3'd0, 1'b0, op_ldi, 3'd2, 1'b1);
      imem_busy = 1'b1; cyc("t4.imem", 0, 0, 1);
      imem_busy = 1'b0; cyc("t4.stall0", 1, 1, 0);
      dmem_busy = 1'b1;
      for (int i = 0; i < 3; i++) cyc("t4.freeze", 0, 0, 1);
      dmem_busy = 1'b0; cyc("t4.stall1", 1, 1, 0);
      cyc("t4.guard", 0, 0, 0);
      idle();

      // 5: flush cancels pending LDI bubble; flush beats hazard in idle
      drv(3'd0, 1'b0, 3'd7, 1'b1, op_ldi, 3'd7, 1'b1);
      cyc("t5.stall0", 1, 1, 0);
      flush = 1'b1; cyc("t5.flush", 0, 0, 0);
      flush = 1'b0; idle(); cyc("t5.after", 0, 0, 0);
      drv(3'd1, 1'b1, 3'd0, 1'b0, op_ldr, 3'd1, 1'b1);
      flush = 1'b1; cyc("t5.flush_idle", 0, 0, 0);
      flush = 1'b0; idle(); cyc("t5.after_idle", 0, 0, 0);

      // 6: reset mid-bubble, then counter saturation
      drv(3'd3, 1'b1, 3'd0, 1'b0, op_ldi, 3'd3, 1'b1);
      cyc("t6.stall0", 1, 1, 0);
      rst = 1'b1;
      @(negedge clk);
      chk("t6.rst.stall_front", 32'(stall_front), 32'd0);
      chk("t6.rst.bubble_ex",   32'(bubble_ex),   32'd0);
      chk("t6.rst.stall_count", 32'(stall_count), 32'd0);
      exp_cnt = 4'd0;
      @(posedge clk); #1;
      rst = 1'b0; idle();
      cyc("t6.post_rst", 0, 0, 0);
      dmem_busy = 1'b1;
      for (int i = 0; i < 18; i++) cyc("t6.sat", 0, 0, 1);
      dmem_busy = 1'b0;
      cyc("t6.hold", 0, 0, 0);
      chk("t6.max", 32'(stall_count), 32'd15);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
